// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, types and write-port priority helper for the register file
package reg_file_pkg;
    localparam int DEF_DATA_WIDTH_POW = 6;
    localparam int DEF_DEPTH_POW      = 5;
    localparam int MAX_WRITE          = 2;
    localparam int PORT_IDX_W         = $clog2(MAX_WRITE);

    typedef logic [DEF_DEPTH_POW-1:0]           reg_addr_t;
    typedef logic [(1 << DEF_DATA_WIDTH_POW)-1:0] reg_data_t;

    // Highest-index set bit of a write-port hit vector; later ports win collisions.
    function automatic logic [PORT_IDX_W-1:0] highest_port(input logic [MAX_WRITE-1:0] hit);
        highest_port = '0;
        for (int j = 0; j < MAX_WRITE; j++)
            if (hit[j]) highest_port = PORT_IDX_W'(j);
    endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits with reserve/release tracking and read ports
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int REG_MEM_DEPTH_POW = DEF_DEPTH_POW,
    parameter int NUM_READ          = 2,
    parameter int BYPASS_EN         = 1,
    parameter int ZERO_REG_EN       = 1,
    localparam int AW               = REG_MEM_DEPTH_POW,
    localparam int DEPTH            = 1 << REG_MEM_DEPTH_POW
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic [DEPTH-1:0]             rel_i,
    input  logic                         reserve_en_i,
    input  logic [AW-1:0]                reserve_rd_i,
    input  logic [NUM_READ-1:0][AW-1:0]  rs_i,
    output logic [NUM_READ-1:0]          busy_o
);
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Reset beats reserve, reserve beats release (a new producer supersedes the old one).
    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            busy_d[k] = reset ? 1'b0
                      : (reserve_en_i && reserve_rd_i == AW'(k) && !(ZERO_REG_EN != 0 && k == 0)) ? 1'b1
                      : rel_i[k] ? 1'b0 : busy_q[k];
    end

    // Read ports: a same-cycle release is visible when bypassing, a same-cycle reserve never is.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++)
            busy_o[i] = (ZERO_REG_EN != 0 && rs_i[i] == '0) ? 1'b0
                      : (BYPASS_EN != 0 && !reset && rel_i[rs_i[i]]) ? 1'b0
                      : busy_q[rs_i[i]];
    end

    // Busy state register; x0 must stay idle and a busy bit may only drop on reset or a write.
    always_ff @(posedge clk_in) begin
        if (ZERO_REG_EN != 0) assert (reset || !busy_q[0]);
        for (int k = 0; k < DEPTH; k++)
            assert (reset || rel_i[k] || !busy_q[k] || busy_d[k]);
        busy_q <= busy_d;
    end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported integer register file with write bypass and busy scoreboard
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = DEF_DATA_WIDTH_POW,
    parameter int REG_MEM_DEPTH_POW  = DEF_DEPTH_POW,
    parameter int NUM_READ           = 2,
    parameter int NUM_WRITE          = 1,
    parameter int BYPASS_EN          = 1,
    parameter int ZERO_REG_EN        = 1,
    localparam int DW                = 1 << REG_DATA_WIDTH_POW,
    localparam int AW                = REG_MEM_DEPTH_POW,
    localparam int DEPTH             = 1 << REG_MEM_DEPTH_POW
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [NUM_READ-1:0][AW-1:0]   rs_in,
    output logic [NUM_READ-1:0][DW-1:0]   reg_data_out,
    output logic [NUM_READ-1:0]           busy_out,
    input  logic [NUM_WRITE-1:0][AW-1:0]  rd_in,
    input  logic [NUM_WRITE-1:0][DW-1:0]  data_write,
    input  logic [NUM_WRITE-1:0]          write_en,
    input  logic                          reserve_en,
    input  logic [AW-1:0]                 reserve_rd
);
    logic [DW-1:0]                 registers_q [DEPTH];
    logic [DW-1:0]                 registers_d [DEPTH];
    logic [MAX_WRITE-1:0]          wr_hit      [DEPTH];
    logic [MAX_WRITE-1:0][DW-1:0]  wdata;
    logic [DEPTH-1:0]              rel;

    // Decode which write ports hit each register; writes to x0 are dropped when it is hardwired.
    always_comb begin
        wdata = '0;
        for (int j = 0; j < NUM_WRITE; j++) wdata[j] = data_write[j];
        for (int k = 0; k < DEPTH; k++) begin
            wr_hit[k] = '0;
            for (int j = 0; j < NUM_WRITE; j++)
                wr_hit[k][j] = write_en[j] && rd_in[j] == AW'(k) && !(ZERO_REG_EN != 0 && k == 0);
            rel[k] = |wr_hit[k];
        end
    end

    // Next register contents: reset clears everything, otherwise the highest hitting port writes.
    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            registers_d[k] = reset ? '0 : rel[k] ? wdata[highest_port(wr_hit[k])] : registers_q[k];
    end

    // Read ports: forward same-cycle write data when bypassing, except during reset.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++)
            reg_data_out[i] = (ZERO_REG_EN != 0 && rs_in[i] == '0) ? '0
                            : (BYPASS_EN != 0 && !reset && rel[rs_in[i]]) ? wdata[highest_port(wr_hit[rs_in[i]])]
                            : registers_q[rs_in[i]];
    end

    // Data array state register; x0 must stay zero when hardwired.
    always_ff @(posedge clk_in) begin
        if (ZERO_REG_EN != 0) assert (reset || registers_q[0] == '0);
        registers_q <= registers_d;
    end

    reg_file_scoreboard #(
        .REG_MEM_DEPTH_POW (REG_MEM_DEPTH_POW),
        .NUM_READ          (NUM_READ),
        .BYPASS_EN         (BYPASS_EN),
        .ZERO_REG_EN       (ZERO_REG_EN)
    ) u_scoreboard (
        .clk_in       (clk_in),
        .reset        (reset),
        .rel_i        (rel),
        .reserve_en_i (reserve_en),
        .reserve_rd_i (reserve_rd),
        .rs_i         (rs_in),
        .busy_o       (busy_out)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: bypassing and registered-view register files against a behavioural model
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic                 clk_in = 1'b0;
    logic                 reset;
    reg_addr_t [1:0]      rs_in;
    reg_addr_t [1:0]      rd_in;
    reg_data_t [1:0]      data_write;
    logic      [1:0]      write_en;
    logic                 reserve_en;
    reg_addr_t            reserve_rd;
    reg_data_t [1:0]      dout_b, dout_r;
    logic      [1:0]      busy_b, busy_r;

    reg_data_t m_data [32];
    bit        m_busy [32];
    int        n_vec = 0;
    int        n_err = 0;

    always #5 clk_in = ~clk_in;

    reg_file_mp #(.NUM_READ(2), .NUM_WRITE(2), .BYPASS_EN(1), .ZERO_REG_EN(1)) u_byp (
        .clk_in(clk_in), .reset(reset), .rs_in(rs_in), .reg_data_out(dout_b), .busy_out(busy_b),
        .rd_in(rd_in), .data_write(data_write), .write_en(write_en),
        .reserve_en(reserve_en), .reserve_rd(reserve_rd)
    );

    reg_file_mp #(.NUM_READ(2), .NUM_WRITE(2), .BYPASS_EN(0), .ZERO_REG_EN(1)) u_reg (
        .clk_in(clk_in), .reset(reset), .rs_in(rs_in), .reg_data_out(dout_r), .busy_out(busy_r),
        .rd_in(rd_in), .data_write(data_write), .write_en(write_en),
        .reserve_en(reserve_en), .reserve_rd(reserve_rd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            reg_data_t exp_b, exp_r;
            logic      eb_b, eb_r;
            int        hit;
            hit = -1;
            for (int j = 0; j < 2; j++)
                if (!reset && write_en[j] && rd_in[j] == rs_in[i] && rs_in[i] != 0) hit = j;
            exp_r = m_data[rs_in[i]];
            eb_r  = m_busy[rs_in[i]];
            exp_b = (hit >= 0) ? data_write[hit] : exp_r;
            eb_b  = (hit >= 0) ? 1'b0 : eb_r;
            chk($sformatf("byp_data[%0d]", i), dout_b[i], exp_b);
            chk($sformatf("byp_busy[%0d]", i), 64'(busy_b[i]), 64'(eb_b));
            chk($sformatf("reg_data[%0d]", i), dout_r[i], exp_r);
            chk($sformatf("reg_busy[%0d]", i), 64'(busy_r[i]), 64'(eb_r));
        end
    endtask

    task automatic model_clock();
        if (reset) begin
            for (int k = 0; k < 32; k++) begin
                m_data[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++)
                if (write_en[j] && rd_in[j] != 0) begin
                    m_data[rd_in[j]] = data_write[j];
                    m_busy[rd_in[j]] = 1'b0;
                end
            if (reserve_en && reserve_rd != 0) m_busy[reserve_rd] = 1'b1;
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] we, input reg_addr_t rd0, input reg_addr_t rd1,
                        input reg_data_t d0, input reg_data_t d1, input logic re, input reg_addr_t rr,
                        input reg_addr_t a0, input reg_addr_t a1);
        reset = rst; write_en = we; rd_in[0] = rd0; rd_in[1] = rd1;
        data_write[0] = d0; data_write[1] = d1; reserve_en = re; reserve_rd = rr;
        rs_in[0] = a0; rs_in[1] = a1;
        #2;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_clock();
        @(negedge clk_in);
    endtask

    initial begin
        reset = 1'b1; write_en = '0; rd_in = '0; data_write = '0;
        reserve_en = 1'b0; reserve_rd = '0; rs_in = '0;
        for (int k = 0; k < 32; k++) begin
            m_data[k] = '0;
            m_busy[k] = 1'b0;
        end
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);

        step(0, 2'b01, 5, 0, 64'hDEAD, 0, 1, 7, 5, 7);            tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 7);
        chk("pre_rst_busy7", 64'(busy_r[1]), 64'd1);               tick();
        step(1, 2'b01, 9, 0, 64'h77, 0, 1, 9, 5, 7);               tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 7);
        chk("rst_data5", dout_b[0], 64'h0);
        chk("rst_busy7", 64'(busy_b[1]), 64'd0);                   tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);                    tick();

        step(0, 2'b01, 3, 0, 64'h1234, 0, 0, 0, 3, 0);
        chk("byp_same", dout_b[0], 64'h1234);
        chk("reg_old", dout_r[0], 64'h0);                          tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("reg_next", dout_r[0], 64'h1234);                      tick();

        step(0, 2'b00, 0, 0, 0, 0, 1, 10, 10, 0);
        chk("rsv_not_byp", 64'(busy_b[0]), 64'd0);                 tick();
        for (int c = 1; c < 4; c++) begin
            step(0, 2'b00, 0, 0, 0, 0, 0, 0, 10, 0);
            chk("rsv_busy", 64'(busy_b[0]), 64'd1);                tick();
        end
        step(0, 2'b01, 10, 0, 64'h55, 0, 0, 0, 10, 0);
        chk("wb_busy_byp", 64'(busy_b[0]), 64'd0);
        chk("wb_data_byp", dout_b[0], 64'h55);                     tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 10, 0);
        chk("wb_stored", dout_r[0], 64'h55);
        chk("wb_busy_reg", 64'(busy_r[0]), 64'd0);                 tick();

        step(0, 2'b01, 8, 0, 64'h99, 0, 1, 8, 8, 0);               tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 8, 0);
        chk("rsv_wr_busy", 64'(busy_b[0]), 64'd1);
        chk("rsv_wr_data", dout_b[0], 64'h99);                     tick();

        step(0, 2'b11, 4, 4, 64'hAA, 64'hBB, 0, 0, 4, 4);
        chk("dual_byp", dout_b[1], 64'hBB);                        tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0);
        chk("dual_stored", dout_r[0], 64'hBB);                     tick();

        step(0, 2'b11, 0, 0, 64'hFFFF, 64'hFFFF, 1, 0, 0, 0);
        chk("x0_byp_data", dout_b[0], 64'h0);
        chk("x0_byp_busy", 64'(busy_b[0]), 64'd0);                 tick();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_data", dout_r[0], 64'h0);
        chk("x0_busy", 64'(busy_r[0]), 64'd0);                     tick();

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 31) == 0, 2'($urandom),
                 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom), 5'($urandom_range(0, 11)),
                 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
